// File: rtl/dbus_sram_responder.sv
// Data-bus responder: SRAM-backed slave for the core's dreq/dresp port pair.
// It returns responses in acceptance order after a programmable minimum latency.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  input  logic       addr_stall,
  input  logic       resp_stall
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int AGE_W = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [AGE_W-1:0] AGE_READY = AGE_W'(LATENCY);

  logic [31:0]      mem         [DEPTH_WORDS];
  logic [31:0]      slot_data_q [MAX_OUTSTANDING];
  logic [AGE_W-1:0] slot_age_q  [MAX_OUTSTANDING];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [IDX_W-1:0] idx;
  logic             is_write;
  logic             accept;
  logic             head_ready;
  logic             pop;
  logic             unused_bits;

  // Byte offset, size and the aliased upper address bits never reach the SRAM.
  assign unused_bits = ^{dreq.addr[31:IDX_W+2], dreq.addr[1:0], dreq.size};

  always_comb begin
    // NOTE: every signal gets a default before any conditional update, so no latch is inferred.
    idx        = dreq.addr[2 +: IDX_W];
    is_write   = |dreq.strobe;
    accept     = dreq.valid & ~addr_stall & (count_q < CNT_MAX);
    head_ready = (count_q != '0) && (slot_age_q[rd_ptr_q] == AGE_READY);
    pop        = head_ready & ~resp_stall;

    dresp.addr_ok = accept;
    dresp.data_ok = pop;
    dresp.data    = pop ? slot_data_q[rd_ptr_q] : 32'h0;

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    wr_ptr_d = wr_ptr_q;
    if (accept) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);

    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Each response slot carries its own age in place of a separate delay line;
  // the head may leave once it has aged LATENCY cycles.
  // NOTE: SRAM and slot payloads are not reset; count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (slot_age_q[i] != AGE_READY) slot_age_q[i] <= slot_age_q[i] + AGE_W'(1);
    end
    if (accept) begin
      slot_data_q[wr_ptr_q] <= is_write ? 32'h0 : mem[idx];
      slot_age_q[wr_ptr_q]  <= AGE_W'(1);
      for (int b = 0; b < 4; b++) begin
        if (dreq.strobe[b]) mem[idx][8*b +: 8] <= dreq.data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: a scoreboard of expected responses,
// filled on each accept and drained by a monitor on every data_ok.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int DEPTH_WORDS     = 1024;
  localparam int LATENCY         = 2;
  localparam int MAX_OUTSTANDING = 4;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       addr_stall;
  logic       resp_stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          cyc;
  } rec_t;

  exp_t        sb[$];
  rec_t        rec[$];
  int          acc_log[$];
  logic [31:0] model[int];
  exp_t        mon_e;

  dbus_sram_responder #(
    .DEPTH_WORDS    (DEPTH_WORDS),
    .LATENCY        (LATENCY),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dreq      (dreq),
    .dresp     (dresp),
    .addr_stall(addr_stall),
    .resp_stall(resp_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) & (DEPTH_WORDS - 1));
  endfunction

  // Response monitor: pops the scoreboard on each data_ok.
  always @(negedge clk) begin
    if (!reset) begin
      if (dresp.data_ok) begin
        if (sb.size() == 0) begin
          check("unexpected_data_ok", 32'(dresp.data_ok), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_data", dresp.data, mon_e.data);
          check("resp_lat_min", 32'(cyc - mon_e.acc_cyc >= LATENCY), 32'h1);
          rec.push_back('{dresp.data, cyc - mon_e.acc_cyc, cyc});
        end
      end else begin
        check("idle_data_zero", dresp.data, 32'h0);
      end
    end
  end

  // Drive one request from posedge+1 and hold it until accepted.
  task automatic issue(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    exp_t        e;
    bit          done;
    logic [31:0] word;
    int          w;
    dreq.valid  = 1'b1;
    dreq.addr   = addr;
    dreq.size   = 3'd2;
    dreq.strobe = strb;
    dreq.data   = data;
    done        = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dresp.addr_ok) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check("accept_timeout", 32'(done), 32'h1);
    end else begin
      w    = widx(addr);
      word = model.exists(w) ? model[w] : 32'h0;
      if (strb != 4'h0) begin
        for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
        model[w] = word;
        e.data   = 32'h0;
      end else begin
        e.data = word;
      end
      e.acc_cyc = cyc;
      sb.push_back(e);
      acc_log.push_back(cyc);
    end
    @(posedge clk);
    #1;
    dreq.valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int rel;
    int n;
    reset      = 1'b1;
    dreq       = '0;
    addr_stall = 1'b0;
    resp_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_data_ok", 32'(dresp.data_ok), 32'h0);
    check("rst_data", dresp.data, 32'h0);
    check("rst_addr_ok", 32'(dresp.addr_ok), 32'h0);
    check("rst_count", 32'(dut.count_q), 32'h0);
    @(posedge clk);
    #1;

    // Read-after-write with default latency
    rec = {}; acc_log = {}; c0 = cyc;
    issue(32'h10, 4'hF, 32'hDEAD_BEEF);
    issue(32'h10, 4'h0, 32'h0);
    drain();
    check("raw_nresp", 32'(rec.size()), 32'd2);
    check("raw_w_accept", acc_log[0], c0);
    check("raw_r_accept", acc_log[1], c0 + 1);
    check("raw_w_lat", rec[0].lat, 32'd2);
    check("raw_w_data", rec[0].data, 32'h0);
    check("raw_r_lat", rec[1].lat, 32'd2);
    check("raw_r_data", rec[1].data, 32'hDEAD_BEEF);

    // Byte strobes
    rec = {};
    issue(32'h20, 4'hF, 32'h1122_3344);
    issue(32'h20, 4'b0101, 32'hAABB_CCDD);
    issue(32'h20, 4'h0, 32'h0);
    drain();
    check("strobe_merge", rec[2].data, 32'h11BB_33DD);

    // Address aliasing modulo SRAM size
    rec = {};
    issue(32'h0000_1004, 4'hF, 32'h1234_5678);
    issue(32'h0000_0004, 4'h0, 32'h0);
    drain();
    check("alias_read", rec[1].data, 32'h1234_5678);

    // Outstanding limit under resp_stall
    for (int i = 0; i < 6; i++) issue(32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
    drain();
    rec = {}; acc_log = {}; rel = 0;
    resp_stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) issue(32'h100 + 32'(4 * i), 4'h0, 32'h0);
      end
      begin
        repeat (8) @(negedge clk);
        check("full_accepts", 32'(acc_log.size()), 32'd4);
        check("full_addr_ok", 32'(dresp.addr_ok), 32'h0);
        @(posedge clk);
        #1;
        resp_stall = 1'b0;
        rel = cyc;
      end
    join
    drain();
    check("full_nresp", 32'(rec.size()), 32'd6);
    check("full_first_resp", rec[0].cyc, rel);
    check("full_reopen", acc_log[4], rel + 1);
    for (int k = 0; k < 6; k++) check("full_order", rec[k].data, 32'hA000_0000 + 32'(k));
    for (int k = 1; k < 6; k++) check("full_consec_resp", rec[k].cyc, rec[0].cyc + k);
    for (int k = 1; k < 4; k++) check("full_consec_acc", acc_log[k], acc_log[0] + k);

    // Address stall for three cycles
    rec = {}; acc_log = {};
    addr_stall  = 1'b1;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h10;
    dreq.size   = 3'd2;
    dreq.strobe = 4'h0;
    dreq.data   = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("stall_no_accept", 32'(dresp.addr_ok), 32'h0);
    end
    @(posedge clk);
    #1;
    addr_stall = 1'b0;
    c0 = cyc;
    issue(32'h10, 4'h0, 32'h0);
    drain();
    check("stall_accept_cyc", acc_log[0], c0);
    check("stall_lat", rec[0].lat, LATENCY);
    check("stall_data", rec[0].data, 32'hDEAD_BEEF);

    // Reset with queued responses
    resp_stall = 1'b1;
    issue(32'h10, 4'h0, 32'h0);
    issue(32'h20, 4'h0, 32'h0);
    issue(32'h04, 4'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    resp_stall = 1'b0;
    rec = {}; acc_log = {}; n = 0;
    repeat (10) begin
      @(negedge clk);
      if (dresp.data_ok) n++;
    end
    check("rst_mid_no_data_ok", n, 32'd0);
    check("rst_mid_count", 32'(dut.count_q), 32'h0);
    @(posedge clk);
    #1;
    resp_stall = 1'b1;
    issue(32'h0000_1004, 4'h0, 32'h0);
    issue(32'h10, 4'h0, 32'h0);
    issue(32'h20, 4'h0, 32'h0);
    issue(32'h04, 4'h0, 32'h0);
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h10;
    dreq.strobe = 4'h0;
    @(negedge clk);
    check("rst_mid_full", 32'(dresp.addr_ok), 32'h0);
    @(posedge clk);
    #1;
    dreq.valid = 1'b0;
    for (int k = 1; k < 4; k++) check("rst_mid_consec_acc", acc_log[k], acc_log[0] + k);
    resp_stall = 1'b0;
    drain();
    check("rst_mid_nresp", 32'(rec.size()), 32'd4);
    check("rst_mid_keep_write", rec[0].data, 32'h1234_5678);
    check("rst_mid_keep_write2", rec[1].data, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
